// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and pointer-sizing helpers used by the
// receive FIFO and its storage array.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   // Smallest n such that 2**n >= value (value >= 1).
   function automatic int unsigned clog2_f(input int unsigned value);
      int unsigned res;
      res = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

   // Pointer carries one extra wrap bit above the address bits.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return clog2_f(depth) + 32'd1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the UART receive FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_rx_fifo_mem
   import uart_pkg::*;
#(
   parameter int ADDR_W = 4
)(
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [UART_DATA_W-1:0] rd_data
);

   logic [UART_DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

   // Write port: capture the byte at the write address.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overflow and level irq.
// Optional saturating drop counter enabled by UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int THRESH     = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_req,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [DEPTH_LOG2:0]    level,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   ovf_clr,
   output logic                   irq
`ifdef UART_RX_FIFO_DROP_CNT_EN
   ,
   output logic [7:0]             drop_cnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = ptr_width(DEPTH);

   typedef logic [PTR_W-1:0] level_t;

   localparam level_t ONE_L    = level_t'(1);
   localparam level_t THRESH_L = level_t'(THRESH);

   level_t wr_ptr_q, wr_ptr_d;
   level_t rd_ptr_q, rd_ptr_d;
   level_t level_q, level_d;
   logic   full_q, full_d;
   logic   empty_q, empty_d;
   logic   overflow_q, overflow_d;
   logic   irq_q, irq_d;
   logic   push_s, pop_s, drop_s;
`ifdef UART_RX_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;
`endif

   // Next-state pointer, flag and status computation.
   always_comb begin
      pop_s  = ~empty_q & rd_ready;
      push_s = wr_req & (~full_q | pop_s);
      drop_s = wr_req & full_q & ~pop_s;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + ONE_L;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + ONE_L;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      level_d = wr_ptr_d - rd_ptr_d;
      full_d  = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
      empty_d = (wr_ptr_d == rd_ptr_d);
      irq_d   = (level_d >= THRESH_L);

      // A fresh drop beats a simultaneous clear so no loss goes unreported.
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end

`ifdef UART_RX_FIFO_DROP_CNT_EN
      if (ovf_clr) begin
         drop_cnt_d = drop_s ? 8'd1 : 8'd0;
      end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
`endif
   end

   // State registers with synchronous reset; storage itself is not reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
         drop_cnt_q <= 8'd0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         irq_q      <= irq_d;
`ifdef UART_RX_FIFO_DROP_CNT_EN
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   uart_rx_fifo_mem #(
      .ADDR_W (PTR_W-1)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_s & ~rst),
      .wr_addr (wr_ptr_q[PTR_W-2:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q[PTR_W-2:0]),
      .rd_data (rd_data)
   );

   assign rd_valid = ~empty_q;
   assign level    = level_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = overflow_q;
   assign irq      = irq_q;
`ifdef UART_RX_FIFO_DROP_CNT_EN
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven vectors plus hand-written
// sequences, with a byte scoreboard checking FWFT output order.
module tb_uart_rx_fifo;

   localparam int DL2    = 4;
   localparam int DEPTH  = 16;
   localparam int THRESH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_req;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [4:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       ovf_clr;
   logic       irq;
`ifdef UART_RX_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH_LOG2(DL2), .THRESH(THRESH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_req   (wr_req),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .level    (level),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .ovf_clr  (ovf_clr),
      .irq      (irq)
`ifdef UART_RX_FIFO_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] m_q[$];
   logic       m_ovf;
   int         m_cnt;

   typedef struct {
      logic       wq;
      logic [7:0] wd;
      logic       rr;
      logic       oc;
      int         lvl;
      logic       vld;
      logic       ovf;
      logic       irq;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, check head byte against scoreboard, update model.
   task automatic step(input logic r, input logic wq, input logic [7:0] wd,
                       input logic rr, input logic oc);
      logic pop_m, push_m, drop_m;
      rst = r; wr_req = wq; wr_data = wd; rd_ready = rr; ovf_clr = oc;
      #1;
      pop_m = (m_q.size() > 0) && rr;
      if (m_q.size() > 0 && !r) begin
         chk("rd_valid_head", int'(rd_valid), 1);
         chk("rd_data_order", int'(rd_data), int'(m_q[0]));
      end
      push_m = wq && ((m_q.size() < DEPTH) || pop_m);
      drop_m = wq && !push_m;
      if (r) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_cnt = 0;
      end else begin
         if (pop_m) void'(m_q.pop_front());
         if (push_m) m_q.push_back(wd);
         if (drop_m) m_ovf = 1'b1;
         else if (oc) m_ovf = 1'b0;
         if (oc) m_cnt = drop_m ? 1 : 0;
         else if (drop_m && m_cnt < 255) m_cnt = m_cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_level"}, int'(level), m_q.size());
      chk({tag, "_full"}, int'(full), int'(m_q.size() == DEPTH));
      chk({tag, "_empty"}, int'(empty), int'(m_q.size() == 0));
      chk({tag, "_valid"}, int'(rd_valid), int'(m_q.size() != 0));
      chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
      chk({tag, "_irq"}, int'(irq), int'(m_q.size() >= THRESH));
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk({tag, "_dropcnt"}, int'(drop_cnt), m_cnt);
`endif
   endtask

   initial begin
      int pushes;
      int cyc;
      logic rr;

      vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h22, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h33, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};

      m_ovf = 1'b0;
      m_cnt = 0;
      rst = 1'b1; wr_req = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; ovf_clr = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      chk("rst_level", int'(level), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_valid", int'(rd_valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_irq", int'(irq), 0);

      for (int i = 0; i < 9; i++) begin
         step(1'b0, vecs[i].wq, vecs[i].wd, vecs[i].rr, vecs[i].oc);
         chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
         chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(vecs[i].vld));
         chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].lvl == 0));
         chk($sformatf("vec%0d_full", i), int'(full), 0);
         chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
         chk($sformatf("vec%0d_irq", i), int'(irq), int'(vecs[i].irq));
      end

      // Fill to full, watching irq come up at THRESH.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
         chk("fill_level", int'(level), i + 1);
         chk("fill_irq", int'(irq), int'(i + 1 >= THRESH));
      end
      chk("fill_full", int'(full), 1);

      // Drop on full, then clear.
      step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      chk("drop_ovf", int'(overflow), 1);
      chk("drop_level", int'(level), 16);
      check_model("drop");
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", int'(overflow), 0);
      check_model("clr");

      // Push and pop together while full: accepted, no overflow.
      step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("fullpp_level", int'(level), 16);
      chk("fullpp_ovf", int'(overflow), 0);
      for (int i = 0; i < DEPTH && m_q.size() > 0; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         check_model("drain1");
      end
      chk("drain1_empty", int'(empty), 1);

      // Random interleave, never dropping.
      pushes = 0;
      cyc = 0;
      while (pushes < 40 && cyc < 400) begin
         rr = 1'($urandom_range(0, 1));
         if (m_q.size() < DEPTH) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)), rr, 1'b0);
            pushes++;
         end else begin
            step(1'b0, 1'b0, 8'h00, rr, 1'b0);
         end
         chk("rand_level_max", int'(level <= 5'd16), 1);
         check_model("rand");
         cyc++;
      end
      chk("rand_pushes", pushes, 40);
      for (int i = 0; i < DEPTH + 1 && m_q.size() > 0; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_model("drain2");

      // Reset mid-drain with a concurrent write.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      chk("pre_rst_ovf", int'(overflow), 1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
      chk("midrst_level", int'(level), 0);
      chk("midrst_valid", int'(rd_valid), 0);
      chk("midrst_ovf", int'(overflow), 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("postrst_valid", int'(rd_valid), 0);
      end
      step(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
      chk("postrst_data", int'(rd_data), 8'h42);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check_model("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
